edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored input channels (legal 2..8).
REQ-002 SHALL have parameter CW, default 2, channel-index width, equal to ceil(log2(NCH)).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; sampled only on clk rising edge.
REQ-005 SHALL have port a  input  NCH  level signals to monitor, one bit per channel.
REQ-006 SHALL have port en  input  NCH  per-channel detect enable.
REQ-007 SHALL have port evt_valid  output  1  event present on output.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts event when high with evt_valid.
REQ-009 SHALL have port evt_chan  output  CW  channel index of presented event.
REQ-010 SHALL have port evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-011 SHALL have port ovf  output  NCH  sticky per-channel overflow flags.
REQ-012 SHALL have port ovf_clr  input  NCH  per-channel overflow clear strobes.

Function
REQ-013 SHALL keep one registered copy prev[i] of a[i] per channel, updated every cycle regardless of en.
REQ-014 SHALL detect rise on channel i when a[i]=1, prev[i]=0, en[i]=1; fall when a[i]=0, prev[i]=1, en[i]=1.
REQ-015 SHALL hold two pending bits per channel (rise, fall), each set on the clock edge its edge is detected.
REQ-016 SHALL, while en[i]=0, ignore new edges on channel i and retain its existing pending bits.
REQ-017 SHALL treat the output slot as free when evt_valid=0 or (evt_valid=1 and evt_ready=1).
REQ-018 SHALL, when the slot is free and any pending bit is set, grant one channel and load evt_valid/evt_chan/evt_rise on that clock edge, clearing the granted pending bit.
REQ-019 SHALL select the granted channel round-robin: search starts at the channel after the last granted one, wrapping NCH-1 -> 0; after reset, search starts at channel 0.
REQ-020 SHALL, when a channel has both bits pending, serve rise first; fall is served on that channel's next grant.
REQ-021 SHALL clear evt_valid when the slot is free and nothing is pending.
REQ-022 SHALL hold evt_valid, evt_chan, evt_rise stable while evt_valid=1 and evt_ready=0.
REQ-023 SHALL give latency of 2 cycles: edge sampled at clock edge t -> evt_valid=1 after edge t+1 when no contention.
REQ-024 SHALL, if a new edge arrives on a pending bit being granted in the same cycle, leave that bit set with no overflow.
REQ-025 SHALL, if a new edge arrives on an already-set pending bit not granted that cycle, keep the bit set, drop the event and set ovf[i].
REQ-026 SHALL clear ovf[i] on ovf_clr[i]=1; simultaneous set and clear leaves ovf[i]=1.
REQ-027 SHALL sustain one event per cycle when evt_ready is held high.

Reset
REQ-028 SHALL, on clk rising edge with rst=0, set evt_valid=0, evt_chan=0, evt_rise=0, ovf=0, all pending bits=0 and round-robin pointer=0.
REQ-029 SHALL load prev[i]=a[i] during reset so no edge is reported on the first cycle after reset release.
REQ-030 SHALL abandon any presented or pending event when reset is asserted mid-operation; no event survives reset.

Configuration
REQ-031 SHALL, when macro EDGE_ARB_SYNC_EN is defined, pass a through a two-flop synchronizer (reset to 0) before prev/detection, raising latency to 4 cycles.
REQ-032 SHALL, without EDGE_ARB_SYNC_EN, sample a directly, with latency per REQ-023.

Verification
REQ-033 SHALL verify single rise: a[2] 0->1 at edge 10, evt_ready=1 -> evt_valid=1, evt_chan=2, evt_rise=1 after edge 11, for one cycle.
REQ-034 SHALL verify round-robin: a[0..3] all rise at same edge, ready=1 -> grants chan 0,1,2,3 on consecutive cycles; next simultaneous burst starts at chan 0 again.
REQ-035 SHALL verify backpressure: evt_ready=0 for 5 cycles with chan 1 event held -> outputs stable; chan 1 rise again during stall -> ovf[1]=1; ovf_clr[1] pulse -> ovf[1]=0.
REQ-036 SHALL verify pulse: a[3] 1-cycle high pulse, ready=1 -> rise then fall events on chan 3 in consecutive cycles, no overflow.
REQ-037 SHALL verify reset: assert rst=0 while evt_valid=1 with pending events and a=4'hF -> all outputs 0 after that edge, no events after release until a changes.
REQ-038 SHALL verify enable: en[1]=0, toggle a[1] -> no chan 1 events; existing chan 1 pending event still delivered.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: detects per-channel rising/falling edges, queues them as pending bits and
// presents them one at a time, round-robin, on a valid/ready port. Optional: EDGE_ARB_SYNC_EN.
module edge_event_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] a,
    input  logic [NCH-1:0] en,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [CW-1:0]  evt_chan,
    output logic           evt_rise,
    output logic [NCH-1:0] ovf,
    input  logic [NCH-1:0] ovf_clr
);

    logic [NCH-1:0] a_s;
    logic [NCH-1:0] prev_q;
    logic [NCH-1:0] rise_det, fall_det;
    logic [NCH-1:0] rise_pend_q, rise_pend_d;
    logic [NCH-1:0] fall_pend_q, fall_pend_d;
    logic [NCH-1:0] pend_any;
    logic [NCH-1:0] gnt_r_vec, gnt_f_vec;
    logic [NCH-1:0] ovf_q, ovf_d, ovf_set;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic           rise_q, rise_d;
    logic           slot_free;
    logic           gnt_found;
    logic [CW-1:0]  gnt_chan;
    logic           gnt_rise;

`ifdef EDGE_ARB_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= a;
            sync2_q <= sync1_q;
        end
    end

    assign a_s = sync2_q;
`else
    assign a_s = a;
`endif

    // Channel index visited at search step k, starting from the pointer and wrapping at NCH.
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NCH) s = s - NCH;
        return CW'(s);
    endfunction

    assign rise_det  = a_s & ~prev_q & en;
    assign fall_det  = ~a_s & prev_q & en;
    assign pend_any  = rise_pend_q | fall_pend_q;
    assign slot_free = ~valid_q | evt_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_chan  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_found && pend_any[rr_idx(ptr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_chan  = rr_idx(ptr_q, k);
            end
        end
        // Rise is served before fall when both are pending on the granted channel.
        gnt_rise = rise_pend_q[gnt_chan];
    end

    always_comb begin
        gnt_r_vec = '0;
        gnt_f_vec = '0;
        valid_d   = valid_q;
        chan_d    = chan_q;
        rise_d    = rise_q;
        ptr_d     = ptr_q;
        if (slot_free) begin
            valid_d = gnt_found;
            if (gnt_found) begin
                chan_d = gnt_chan;
                rise_d = gnt_rise;
                ptr_d  = (gnt_chan == CW'(NCH - 1)) ? '0 : gnt_chan + 1'b1;
                if (gnt_rise) begin
                    gnt_r_vec[gnt_chan] = 1'b1;
                end else begin
                    gnt_f_vec[gnt_chan] = 1'b1;
                end
            end
        end
    end

    // A new edge on a bit granted this cycle simply re-arms it; otherwise a set bit drops it.
    assign rise_pend_d = (rise_pend_q & ~gnt_r_vec) | rise_det;
    assign fall_pend_d = (fall_pend_q & ~gnt_f_vec) | fall_det;
    assign ovf_set     = (rise_det & rise_pend_q & ~gnt_r_vec) |
                         (fall_det & fall_pend_q & ~gnt_f_vec);
    assign ovf_d       = (ovf_q & ~ovf_clr) | ovf_set;

    always_ff @(posedge clk) begin
        prev_q <= a_s;
        if (!rst) begin
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            chan_q      <= '0;
            rise_q      <= 1'b0;
        end else begin
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            chan_q      <= chan_d;
            rise_q      <= rise_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_chan  = chan_q;
    assign evt_rise  = rise_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed vector table followed by randomized traffic checked
// against a behavioural model of the edge/pending/round-robin rules.
module tb_edge_event_arbiter;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] a = '0;
    logic [NCH-1:0] en = '0;
    logic           evt_ready = 1'b0;
    logic [NCH-1:0] ovf_clr = '0;
    logic           evt_valid;
    logic [CW-1:0]  evt_chan;
    logic           evt_rise;
    logic [NCH-1:0] ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .en        (en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] en;
        logic       rdy;
        logic [3:0] clr;
        logic       v;
        logic [1:0] ch;
        logic       r;
        logic [3:0] ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r_, input logic [3:0] a_, input logic [3:0] en_,
                       input logic rdy_, input logic [3:0] clr_, input logic v_,
                       input logic [1:0] ch_, input logic rise_, input logic [3:0] ov_);
        vec_t t;
        t.rst = r_; t.a = a_; t.en = en_; t.rdy = rdy_; t.clr = clr_;
        t.v = v_; t.ch = ch_; t.r = rise_; t.ov = ov_;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs for one rising edge, then sample outputs 1ns later.
    task automatic drive(input logic r_, input logic [3:0] a_, input logic [3:0] en_,
                         input logic rdy_, input logic [3:0] clr_);
        rst = r_; a = a_; en = en_; evt_ready = rdy_; ovf_clr = clr_;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state.
    bit m_prev[NCH];
    bit m_pr[NCH];
    bit m_pf[NCH];
    bit m_ovf[NCH];
    int m_last;
    bit m_v;
    int m_ch;
    bit m_r;

    task automatic model_step(input logic r_, input logic [3:0] a_, input logic [3:0] en_,
                              input logic rdy_, input logic [3:0] clr_);
        bit found;
        bit drop;
        int c;
        if (!r_) begin
            for (int i = 0; i < NCH; i++) begin
                m_pr[i] = 0; m_pf[i] = 0; m_ovf[i] = 0; m_prev[i] = a_[i];
            end
            m_last = NCH - 1;
            m_v = 0; m_ch = 0; m_r = 0;
        end else begin
            if (!m_v || rdy_) begin
                found = 0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last + k) % NCH;
                    if (!found && (m_pr[c] || m_pf[c])) begin
                        found = 1;
                        m_ch = c;
                        m_last = c;
                        m_r = m_pr[c];
                        if (m_pr[c]) m_pr[c] = 0;
                        else m_pf[c] = 0;
                    end
                end
                m_v = found;
            end
            for (int i = 0; i < NCH; i++) begin
                drop = 0;
                if (en_[i] && a_[i] && !m_prev[i]) begin
                    if (m_pr[i]) drop = 1;
                    else m_pr[i] = 1;
                end
                if (en_[i] && !a_[i] && m_prev[i]) begin
                    if (m_pf[i]) drop = 1;
                    else m_pf[i] = 1;
                end
                m_ovf[i] = (m_ovf[i] && !clr_[i]) || drop;
                m_prev[i] = a_[i];
            end
        end
    endtask

    function automatic int model_ovf();
        int s = 0;
        for (int i = 0; i < NCH; i++) if (m_ovf[i]) s |= (1 << i);
        return s;
    endfunction

    initial begin
        // rst a en rdy clr | valid chan rise ovf
        add(0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);  // reset
        add(0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);  // round-robin burst of rises
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 1, 1, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 2, 1, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 3, 1, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);  // second burst (falls) restarts at 0
        add(1, 4'h0, 4'hF, 1, 4'h0, 1, 0, 0, 4'h0);
        add(1, 4'h0, 4'hF, 1, 4'h0, 1, 1, 0, 4'h0);
        add(1, 4'h0, 4'hF, 1, 4'h0, 1, 2, 0, 4'h0);
        add(1, 4'h0, 4'hF, 1, 4'h0, 1, 3, 0, 4'h0);
        add(1, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h4, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);  // single rise on chan 2
        add(1, 4'h4, 4'hF, 1, 4'h0, 1, 2, 1, 4'h0);
        add(1, 4'h4, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hC, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);  // one-cycle pulse on chan 3
        add(1, 4'h4, 4'hF, 1, 4'h0, 1, 3, 1, 4'h0);
        add(1, 4'h4, 4'hF, 1, 4'h0, 1, 3, 0, 4'h0);
        add(1, 4'h4, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h6, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);  // backpressure on chan 1
        add(1, 4'h6, 4'hF, 0, 4'h0, 1, 1, 1, 4'h0);
        add(1, 4'h4, 4'hF, 0, 4'h0, 1, 1, 1, 4'h0);
        add(1, 4'h6, 4'hF, 0, 4'h0, 1, 1, 1, 4'h0);
        add(1, 4'h4, 4'hF, 0, 4'h0, 1, 1, 1, 4'h2);
        add(1, 4'h6, 4'hF, 0, 4'h0, 1, 1, 1, 4'h2);
        add(1, 4'h6, 4'hF, 0, 4'h0, 1, 1, 1, 4'h2);
        add(1, 4'h6, 4'hF, 1, 4'h2, 1, 1, 1, 4'h0);
        add(1, 4'h6, 4'hF, 1, 4'h0, 1, 1, 0, 4'h0);
        add(1, 4'h6, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h5, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0);  // enable: chan 1 fall pending, then disabled
        add(1, 4'h5, 4'hD, 0, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'h7, 4'hD, 0, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'h5, 4'hD, 0, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'h5, 4'hD, 1, 4'h0, 1, 1, 0, 4'h0);
        add(1, 4'h5, 4'hD, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h7, 4'hD, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h5, 4'hD, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h7, 4'hD, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'h7, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0);  // reset mid-operation
        add(1, 4'hE, 4'hF, 0, 4'h0, 1, 3, 1, 4'h0);
        add(1, 4'hE, 4'hF, 0, 4'h0, 1, 3, 1, 4'h0);
        add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hE, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hE, 4'hF, 1, 4'h0, 1, 0, 0, 4'h0);
        add(1, 4'hE, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0);  // overflow set/clear collision
        add(1, 4'hE, 4'hF, 0, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'hF, 4'hF, 0, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'hE, 4'hF, 0, 4'h1, 1, 0, 1, 4'h1);
        add(1, 4'hE, 4'hF, 0, 4'h1, 1, 0, 1, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 0, 1, 4'h0);  // edge on the bit being granted
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 0, 1, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 1, 0, 0, 4'h0);
        add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].a, vecs[i].en, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d valid", i), int'(evt_valid), int'(vecs[i].v));
            check($sformatf("vec%0d ovf", i), int'(ovf), int'(vecs[i].ov));
            if (vecs[i].v || !vecs[i].rst) begin
                check($sformatf("vec%0d chan", i), int'(evt_chan), int'(vecs[i].ch));
                check($sformatf("vec%0d rise", i), int'(evt_rise), int'(vecs[i].r));
            end
        end

        // Randomized traffic against the model, starting from a common reset.
        begin
            logic [3:0] ra, ren, rclr;
            logic       rr, rrdy;
            ra = 4'h0;
            for (int n = 0; n < 800; n++) begin
                ra   = ra ^ 4'($urandom & $urandom);
                ren  = ~4'($urandom & $urandom & $urandom);
                rrdy = ($urandom_range(0, 3) != 0);
                rclr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
                rr   = (n < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
                model_step(rr, ra, ren, rrdy, rclr);
                drive(rr, ra, ren, rrdy, rclr);
                check($sformatf("rnd%0d valid", n), int'(evt_valid), int'(m_v));
                check($sformatf("rnd%0d ovf", n), int'(ovf), model_ovf());
                if (m_v) begin
                    check($sformatf("rnd%0d chan", n), int'(evt_chan), m_ch);
                    check($sformatf("rnd%0d rise", n), int'(evt_rise), int'(m_r));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
